// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: two read ports with hazard flags,
// an issue port that marks destinations busy, and the writeback port.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra;
    logic [AW-1:0]   rb;
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic            busy_a;
    logic            busy_b;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            wen;
    logic [AW-1:0]   rc;
    logic [XLEN-1:0] dc;
    logic            wb_clr;
    logic            any_busy;

    modport master (
        output ra, rb, iss_en, iss_rd, wen, rc, dc, wb_clr,
        input  da, db, busy_a, busy_b, any_busy
    );

    modport slave (
        input  ra, rb, iss_en, iss_rd, wen, rc, dc, wb_clr,
        output da, db, busy_a, busy_b, any_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         res_n,
    regfile_sb_if.slave  bus
);
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (HAS_ZERO && gi == 0) begin : g_zero
                assign mem[gi]  = '0;
                assign busy[gi] = 1'b0;
            end else begin : g_live
                logic [XLEN-1:0] data_reg;
                logic            busy_reg;
                logic            busy_next;
                logic            wr_hit;

                assign wr_hit = bus.wen && (bus.rc == AW'(gi));

                // Issue is applied after the clear so a new producer wins a collision.
                always_comb begin
                    busy_next = busy_reg;
                    if (wr_hit && bus.wb_clr) begin
                        busy_next = 1'b0;
                    end
                    if (bus.iss_en && (bus.iss_rd == AW'(gi))) begin
                        busy_next = 1'b1;
                    end
                end

                always_ff @(posedge clk or negedge res_n) begin
                    if (!res_n) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        if (wr_hit) begin
                            data_reg <= bus.dc;
                        end
                        busy_reg <= busy_next;
                    end
                end

                assign mem[gi]  = data_reg;
                assign busy[gi] = busy_reg;
            end
        end
    endgenerate

    logic a_zero;
    logic b_zero;
    logic a_fwd;
    logic b_fwd;

    assign a_zero = HAS_ZERO && (bus.ra == '0);
    assign b_zero = HAS_ZERO && (bus.rb == '0);
    assign a_fwd  = HAS_BYP && bus.wen && (bus.rc == bus.ra);
    assign b_fwd  = HAS_BYP && bus.wen && (bus.rc == bus.rb);

    // Outputs are gated by res_n so the bypass cannot leak dc while in reset.
    always_comb begin
        bus.da     = '0;
        bus.busy_a = 1'b0;
        if (res_n && !a_zero) begin
            bus.da     = a_fwd ? bus.dc : mem[bus.ra];
            bus.busy_a = busy[bus.ra] && !(a_fwd && bus.wb_clr);
        end
    end

    always_comb begin
        bus.db     = '0;
        bus.busy_b = 1'b0;
        if (res_n && !b_zero) begin
            bus.db     = b_fwd ? bus.dc : mem[bus.rb];
            bus.busy_b = busy[bus.rb] && !(b_fwd && bus.wb_clr);
        end
    end

    assign bus.any_busy = |busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default build (zero reg, bypass) and a
// 64-bit/16-entry build without zero reg or bypass, driven side by side.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .AW(5)) bus0();
    regfile_sb_if #(.XLEN(64), .AW(4)) bus1();

    regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .res_n(res_n), .bus(bus0)
    );
    regfile_sb #(.XLEN(64), .NREGS(16), .AW(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .res_n(res_n), .bus(bus1)
    );

    typedef enum int {DA0, DB0, BA0, BB0, AB0, DA1, DB1, BA1, BB1, AB1} sig_e;
    typedef struct {
        sig_e        sig;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m0 [32];
    logic        b0 [32];
    logic [63:0] m1 [16];
    logic        b1 [16];

    function automatic void push(input sig_e s, input logic [63:0] v, input string tag);
        exp_t e;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        sb_q.push_back(e);
    endfunction

    function automatic logic [63:0] obs(input sig_e s);
        case (s)
            DA0: return {32'h0, bus0.da};
            DB0: return {32'h0, bus0.db};
            BA0: return {63'h0, bus0.busy_a};
            BB0: return {63'h0, bus0.busy_b};
            AB0: return {63'h0, bus0.any_busy};
            DA1: return bus1.da;
            DB1: return bus1.db;
            BA1: return {63'h0, bus1.busy_a};
            BB1: return {63'h0, bus1.busy_b};
            AB1: return {63'h0, bus1.any_busy};
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic ie,
                         input logic [4:0] ird, input logic we, input logic [4:0] rc,
                         input logic [63:0] dc, input logic clr);
        bus0.ra = ra;       bus0.rb = rb;       bus0.iss_en = ie;  bus0.iss_rd = ird;
        bus0.wen = we;      bus0.rc = rc;       bus0.dc = dc[31:0]; bus0.wb_clr = clr;
        bus1.ra = ra[3:0];  bus1.rb = rb[3:0];  bus1.iss_en = ie;  bus1.iss_rd = ird[3:0];
        bus1.wen = we;      bus1.rc = rc[3:0];  bus1.dc = dc;      bus1.wb_clr = clr;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    drive(5, 5, 1, 5, 1, 5, 64'h1111, 0);
                    push(DA0, 0, "rst_hold_da"); push(BA0, 0, "rst_hold_busy");
                    push(AB0, 0, "rst_hold_any"); push(DA1, 0, "rst_hold_da1"); push(AB1, 0, "rst_hold_any1");
                end
                1: begin
                    drive(5, 5, 0, 0, 0, 0, 0, 0);
                    push(DA0, 0, "rst_write_ignored"); push(DA1, 0, "rst_write_ignored1"); push(BA0, 0, "rst_issue_ignored");
                end
                2: begin
                    drive(5, 5, 1, 5, 1, 5, 64'hDEADBEEF, 0);
                    push(DA0, 64'hDEADBEEF, "preload_bypass"); push(DA1, 0, "preload_nobypass"); push(BA0, 0, "preload_busy_pre");
                end
                3: begin
                    drive(5, 5, 0, 0, 0, 0, 0, 0);
                    push(DA0, 64'hDEADBEEF, "preload_da"); push(BA0, 1, "preload_busy"); push(AB0, 1, "preload_any");
                    push(DA1, 64'hDEADBEEF, "preload_da1"); push(BA1, 1, "preload_busy1"); push(AB1, 1, "preload_any1");
                end
                default: begin
                    drive(5, 5, 0, 0, 0, 0, 0, 0);
                    push(DA0, 0, "async_rst_da"); push(BA0, 0, "async_rst_busy"); push(AB0, 0, "async_rst_any");
                    push(DA1, 0, "async_rst_da1"); push(AB1, 0, "async_rst_any1");
                end
            endcase
            if (k == 4) begin
                #2 res_n = 1'b0;
                #1;
            end else begin
                @(negedge clk);
            end
            $display("test_reset step %0d res_n=%b da0=%h busy_a0=%b any0=%b", k, res_n, bus0.da, bus0.busy_a, bus0.any_busy);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            if (k == 0) begin
                drive(5, 5, 0, 0, 0, 0, 0, 0);
                res_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_reg();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    drive(0, 0, 1, 0, 1, 0, 64'hFFFFFFFF, 0);
                    push(DA0, 0, "zero_same_da"); push(BA0, 0, "zero_same_busy");
                    push(DA1, 0, "r0_same_da1"); push(BA1, 0, "r0_same_busy1");
                end
                1: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0);
                    push(DA0, 0, "zero_da"); push(BA0, 0, "zero_busy"); push(AB0, 0, "zero_any");
                    push(DA1, 64'hFFFFFFFF, "r0_da1"); push(DB1, 64'hFFFFFFFF, "r0_db1");
                    push(BA1, 1, "r0_busy1"); push(AB1, 1, "r0_any1");
                end
                2: begin
                    drive(0, 0, 0, 0, 1, 0, 0, 1);
                    push(DA0, 0, "zero_da_clr"); push(BA1, 1, "r0_busy_nobypass");
                end
                default: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0);
                    push(BA1, 0, "r0_cleared1"); push(AB1, 0, "r0_any_cleared1"); push(DA1, 0, "r0_rewritten1");
                end
            endcase
            @(negedge clk);
            $display("test_zero_reg step %0d da0=%h da1=%h busy_a1=%b", k, bus0.da, bus1.da, bus1.busy_a);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    drive(7, 7, 0, 0, 1, 7, 64'h0BADF00D, 0);
                    push(DA0, 64'h0BADF00D, "byp_first_da"); push(DA1, 0, "nobyp_first_da1");
                end
                1: begin
                    drive(7, 7, 0, 0, 1, 7, 64'h12345678, 0);
                    push(DA0, 64'h12345678, "byp_da"); push(DB0, 64'h12345678, "byp_db");
                    push(DA1, 64'h0BADF00D, "nobyp_old_da1"); push(DB1, 64'h0BADF00D, "nobyp_old_db1");
                end
                default: begin
                    drive(7, 7, 0, 0, 0, 0, 0, 0);
                    push(DA0, 64'h12345678, "byp_after_da");
                    push(DA1, 64'h12345678, "nobyp_new_da1"); push(DB1, 64'h12345678, "nobyp_new_db1");
                end
            endcase
            @(negedge clk);
            $display("test_bypass step %0d da0=%h db0=%h da1=%h db1=%h", k, bus0.da, bus0.db, bus1.da, bus1.db);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    drive(3, 3, 1, 3, 0, 0, 0, 0);
                    push(BA0, 0, "sb_issue_same"); push(AB0, 0, "sb_any_same"); push(BA1, 0, "sb_issue_same1");
                end
                1: begin
                    drive(3, 3, 0, 0, 1, 3, 64'h55, 1);
                    push(BA0, 0, "sb_fwd_resolves"); push(BB0, 0, "sb_fwd_resolves_b"); push(DA0, 64'h55, "sb_fwd_da");
                    push(AB0, 1, "sb_any_set"); push(BA1, 1, "sb_busy1"); push(DA1, 0, "sb_old_da1"); push(AB1, 1, "sb_any_set1");
                end
                default: begin
                    drive(3, 3, 0, 0, 0, 0, 0, 0);
                    push(BA0, 0, "sb_cleared"); push(AB0, 0, "sb_any_cleared"); push(DA0, 64'h55, "sb_da");
                    push(BA1, 0, "sb_cleared1"); push(AB1, 0, "sb_any_cleared1"); push(DA1, 64'h55, "sb_da1");
                end
            endcase
            @(negedge clk);
            $display("test_scoreboard step %0d busy_a0=%b any0=%b busy_a1=%b any1=%b", k, bus0.busy_a, bus0.any_busy, bus1.busy_a, bus1.any_busy);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: begin
                    drive(10, 9, 1, 9, 0, 0, 0, 0);
                    push(BB0, 0, "col_pre");
                end
                1: begin
                    drive(10, 9, 1, 9, 1, 9, 64'hA5, 1);
                    push(DB0, 64'hA5, "col_fwd_db"); push(BB0, 0, "col_fwd_busy");
                    push(DB1, 0, "col_old_db1"); push(BB1, 1, "col_busy1");
                end
                2: begin
                    drive(10, 9, 0, 0, 0, 0, 0, 0);
                    push(DB0, 64'hA5, "col_data"); push(BB0, 1, "col_set_wins"); push(BA0, 0, "col_other");
                    push(DB1, 64'hA5, "col_data1"); push(BB1, 1, "col_set_wins1");
                end
                3: begin
                    drive(10, 9, 1, 10, 1, 9, 64'hA5, 1);
                    push(BA0, 0, "split_pre"); push(BB1, 1, "split_pre1");
                end
                4: begin
                    drive(10, 9, 0, 0, 0, 0, 0, 0);
                    push(BA0, 1, "split_set"); push(BB0, 0, "split_clr"); push(AB0, 1, "split_any");
                    push(BA1, 1, "split_set1"); push(BB1, 0, "split_clr1");
                end
                5: begin
                    drive(10, 9, 0, 0, 1, 10, 64'h77, 0);
                    push(BA0, 1, "noclr_fwd_busy"); push(DA0, 64'h77, "noclr_fwd_da");
                end
                6: begin
                    drive(10, 9, 0, 0, 0, 0, 0, 0);
                    push(BA0, 1, "noclr_busy"); push(DA0, 64'h77, "noclr_da");
                    push(BA1, 1, "noclr_busy1"); push(DA1, 64'h77, "noclr_da1");
                end
                7: begin
                    drive(10, 9, 0, 0, 1, 10, 64'h77, 1);
                    push(BA0, 0, "clr10_fwd"); push(BA1, 1, "clr10_old1");
                end
                8: begin
                    drive(10, 11, 0, 0, 1, 11, 0, 1);
                    push(BA0, 0, "clr10_done"); push(AB0, 0, "clr10_any"); push(AB1, 0, "clr10_any1");
                    push(BB0, 0, "stray_clr_fwd");
                end
                default: begin
                    drive(10, 11, 0, 0, 0, 0, 0, 0);
                    push(BB0, 0, "stray_clr"); push(AB0, 0, "stray_any");
                    push(BB1, 0, "stray_clr1"); push(AB1, 0, "stray_any1");
                end
            endcase
            @(negedge clk);
            $display("test_collision step %0d busy_a0=%b busy_b0=%b busy_a1=%b busy_b1=%b", k, bus0.busy_a, bus0.busy_b, bus1.busy_a, bus1.busy_b);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wide();
        exp_t e;
        logic [63:0] got;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                drive(15, 15, 0, 0, 1, 15, 64'h0123456789ABCDEF, 0);
                push(DA0, 64'h89ABCDEF, "wide_byp_da0"); push(DA1, 0, "wide_old_da1");
            end else begin
                drive(15, 15, 0, 0, 0, 0, 0, 0);
                push(DA0, 64'h89ABCDEF, "wide_da0");
                push(DA1, 64'h0123456789ABCDEF, "wide_da1"); push(DB1, 64'h0123456789ABCDEF, "wide_db1");
            end
            @(negedge clk);
            $display("test_wide step %0d da0=%h da1=%h", k, bus0.da, bus1.da);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s (%s): got 0x%h expected 0x%h", e.tag, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random(input int ncyc);
        exp_t e;
        logic [63:0] got;
        logic [4:0] ra, rb, ird, rc;
        logic [3:0] ra4, rb4, ird4, rc4;
        logic ie, we, clr, any0, any1;
        logic [63:0] dc;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 res_n = 1'b0;
        for (int i = 0; i < 32; i++) begin m0[i] = '0; b0[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin m1[i] = '0; b1[i] = 1'b0; end
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < ncyc; n++) begin
            ra = 5'($urandom); rb = 5'($urandom); ird = 5'($urandom); rc = 5'($urandom);
            ie = ($urandom_range(0, 2) == 0);
            we = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 2) != 0);
            dc = {$urandom, $urandom};
            ra4 = ra[3:0]; rb4 = rb[3:0]; ird4 = ird[3:0]; rc4 = rc[3:0];
            drive(ra, rb, ie, ird, we, rc, dc, clr);
            any0 = 1'b0;
            any1 = 1'b0;
            for (int i = 0; i < 32; i++) any0 = any0 | b0[i];
            for (int i = 0; i < 16; i++) any1 = any1 | b1[i];
            push(DA0, (ra == 0) ? 64'h0 : (we && rc == ra) ? {32'h0, dc[31:0]} : {32'h0, m0[ra]}, "rnd_da0");
            push(DB0, (rb == 0) ? 64'h0 : (we && rc == rb) ? {32'h0, dc[31:0]} : {32'h0, m0[rb]}, "rnd_db0");
            push(BA0, (ra == 0 || (we && clr && rc == ra)) ? 64'h0 : {63'h0, b0[ra]}, "rnd_ba0");
            push(BB0, (rb == 0 || (we && clr && rc == rb)) ? 64'h0 : {63'h0, b0[rb]}, "rnd_bb0");
            push(AB0, {63'h0, any0}, "rnd_ab0");
            push(DA1, m1[ra4], "rnd_da1");
            push(DB1, m1[rb4], "rnd_db1");
            push(BA1, {63'h0, b1[ra4]}, "rnd_ba1");
            push(BB1, {63'h0, b1[rb4]}, "rnd_bb1");
            push(AB1, {63'h0, any1}, "rnd_ab1");
            @(negedge clk);
            $display("rnd %0d ra=%0d rb=%0d iss=%b/%0d wen=%b rc=%0d clr=%b any0=%b any1=%b",
                     n, ra, rb, ie, ird, we, rc, clr, bus0.any_busy, bus1.any_busy);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = obs(e.sig);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d (%s): got 0x%h expected 0x%h", e.tag, n, e.sig.name(), got, e.val);
                end
            end
            @(posedge clk);
            if (we && clr && rc != 0) b0[rc] = 1'b0;
            if (ie && ird != 0) b0[ird] = 1'b1;
            if (we && rc != 0) m0[rc] = dc[31:0];
            if (we && clr) b1[rc4] = 1'b0;
            if (ie) b1[ird4] = 1'b1;
            if (we) m1[rc4] = dc;
            #1;
        end
    endtask

    initial begin
        res_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_wide();
        test_random(10000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
